// File: rtl/conv_window_fetch.sv
// 3x3 window fetcher: streams windows of a 64x64 8-bit image read from a synchronous BRAM.
// Optional macro ZERO_PAD_EN selects "same" zero padding; the default build is valid convolution.
module conv_window_fetch #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [71:0]       win_data,
    output logic [5:0]        win_row,
    output logic [5:0]        win_col,
    output logic              win_last
);

`ifdef ZERO_PAD_EN
    localparam logic [5:0] LAST_ROW = 6'(IMG_H - 1);
    localparam logic [5:0] LAST_COL = 6'(IMG_W - 1);
`else
    localparam logic [5:0] LAST_ROW = 6'(IMG_H - 3);
    localparam logic [5:0] LAST_COL = 6'(IMG_W - 3);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r, state_n;
    logic [5:0]        row_r, col_r, row_n, col_n;
    logic [1:0]        ti_r, tj_r, ti_s, tj_s;
    logic              issuing_r, issue_s, shift_s, hs_s, last_hs_s, start_ok_s, cap_last_s;
    logic              s0_v_r, s1_v_r;
    logic [3:0]        s0_k_r, s1_k_r, k_s;
    logic [7:0]        pr_s, pc_s, cap_byte_s;
    logic [ADDR_W-1:0] addr_s, rd_addr_r;
    logic [71:0]       win_data_r;
    logic              win_valid_r, win_last_r, busy_r, done_r;
`ifdef ZERO_PAD_EN
    logic              oob_s, s0_pad_r, s1_pad_r;
`endif

    assign rd_addr   = rd_addr_r;
    assign win_data  = win_data_r;
    assign win_valid = win_valid_r;
    assign win_last  = win_last_r;
    assign win_row   = row_r;
    assign win_col   = col_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state, next window position and the tap to read this cycle.
    always_comb begin
        state_n    = state_r;
        row_n      = row_r;
        col_n      = col_r;
        issue_s    = 1'b0;
        ti_s       = ti_r;
        tj_s       = tj_r;
        shift_s    = 1'b0;
        hs_s       = 1'b0;
        last_hs_s  = 1'b0;
        start_ok_s = 1'b0;
        cap_last_s = s1_v_r && (s1_k_r == 4'd8);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n    = FILL;
                    start_ok_s = 1'b1;
                    issue_s    = 1'b1;
                    row_n      = 6'd0;
                    col_n      = 6'd0;
                    ti_s       = 2'd0;
                    tj_s       = 2'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            FILL, SHIFT: begin
                issue_s = issuing_r;
                if (cap_last_s) begin
                    state_n = HOLD;
                end else begin
                    state_n = state_r;
                end
            end
            HOLD: begin
                if (win_ready) begin
                    hs_s = 1'b1;
                    if (col_r != LAST_COL) begin
                        state_n = SHIFT;
                        col_n   = col_r + 6'd1;
                        issue_s = 1'b1;
                        shift_s = 1'b1;
                        ti_s    = 2'd0;
                        tj_s    = 2'd2;
                    end else if (row_r != LAST_ROW) begin
                        state_n = FILL;
                        row_n   = row_r + 6'd1;
                        col_n   = 6'd0;
                        issue_s = 1'b1;
                        ti_s    = 2'd0;
                        tj_s    = 2'd0;
                    end else begin
                        state_n   = DONE;
                        last_hs_s = 1'b1;
                    end
                end else begin
                    state_n = HOLD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pixel coordinate, BRAM address and tap slot of the read issued this cycle.
    always_comb begin
        k_s = {1'b0, ti_s, 1'b0} + {2'b00, ti_s} + {2'b00, tj_s};
`ifdef ZERO_PAD_EN
        // Coordinates below zero wrap to large values, so one compare covers both edges.
        pr_s   = {2'b00, row_n} + {6'd0, ti_s} - 8'd1;
        pc_s   = {2'b00, col_n} + {6'd0, tj_s} - 8'd1;
        oob_s  = (pr_s >= 8'(IMG_H)) || (pc_s >= 8'(IMG_W));
        addr_s = oob_s ? {ADDR_W{1'b0}}
                       : ADDR_W'(pr_s) * ADDR_W'(IMG_W) + ADDR_W'(pc_s);
        cap_byte_s = s1_pad_r ? 8'd0 : rd_data;
`else
        pr_s   = {2'b00, row_n} + {6'd0, ti_s};
        pc_s   = {2'b00, col_n} + {6'd0, tj_s};
        addr_s = ADDR_W'(pr_s) * ADDR_W'(IMG_W) + ADDR_W'(pc_s);
        cap_byte_s = rd_data;
`endif
    end

`ifdef ZERO_PAD_EN
    // Out-of-image flag travels with its read so the captured byte can be forced to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_pad_r <= 1'b0;
            s1_pad_r <= 1'b0;
        end else begin
            s0_pad_r <= issue_s & oob_s;
            s1_pad_r <= s0_pad_r;
        end
    end
`endif

    // Read issue, two-stage capture pipeline matching BRAM latency, and window outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r       <= 6'd0;
            col_r       <= 6'd0;
            ti_r        <= 2'd0;
            tj_r        <= 2'd0;
            issuing_r   <= 1'b0;
            rd_addr_r   <= {ADDR_W{1'b0}};
            s0_v_r      <= 1'b0;
            s0_k_r      <= 4'd0;
            s1_v_r      <= 1'b0;
            s1_k_r      <= 4'd0;
            win_data_r  <= 72'd0;
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            row_r <= row_n;
            col_r <= col_n;
            if (issue_s) begin
                rd_addr_r <= addr_s;
                s0_v_r    <= 1'b1;
                s0_k_r    <= k_s;
                issuing_r <= !((ti_s == 2'd2) && (tj_s == 2'd2));
                if (ti_s == 2'd2) begin
                    ti_r <= 2'd0;
                    tj_r <= tj_s + 2'd1;
                end else begin
                    ti_r <= ti_s + 2'd1;
                    tj_r <= tj_s;
                end
            end else begin
                s0_v_r <= 1'b0;
            end
            s1_v_r <= s0_v_r;
            s1_k_r <= s0_k_r;
            if (shift_s) begin
                for (int i = 0; i < 3; i++) begin
                    win_data_r[24*i +: 8]     <= win_data_r[24*i + 8 +: 8];
                    win_data_r[24*i + 8 +: 8] <= win_data_r[24*i + 16 +: 8];
                end
            end else if (s1_v_r) begin
                win_data_r[8*s1_k_r +: 8] <= cap_byte_s;
            end
            if (cap_last_s) begin
                win_valid_r <= 1'b1;
                win_last_r  <= (row_r == LAST_ROW) && (col_r == LAST_COL);
            end else if (hs_s) begin
                win_valid_r <= 1'b0;
                win_last_r  <= 1'b0;
            end
            if (start_ok_s) begin
                busy_r <= 1'b1;
            end else if (last_hs_s) begin
                busy_r <= 1'b0;
            end
            done_r <= last_hs_s;
        end
    end

endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Reads a 64x64 8-bit image out of the image BRAM through its synchronous read port and emits a stream of 3x3 pixel windows for the convolution engine. It sits directly downstream of the image BRAM and owns that BRAM's read port during inference. Adjacent windows along a row reuse six pixels through a column shift, so a row step costs 3 reads instead of 9. Windows leave on a valid/ready handshake and are held stable under backpressure.

## Interface

Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 64, image height in pixels
- ADDR_W, 12, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a full-image pass when idle
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse after the last window handshake
- rd_addr  output  ADDR_W  BRAM read address (row*IMG_W + col), registered
- rd_data  input  8  BRAM read data; valid one cycle after rd_addr is sampled
- win_valid  output  1  win_data holds a complete window
- win_ready  input  1  consumer accepts the window when high with win_valid
- win_data  output  72  tap k = 3*i + j at bits [8k+7:8k]; i is the row offset, j the column offset; tap 0 is top-left
- win_row  output  6  window row index
- win_col  output  6  window column index
- win_last  output  1  high with the final window of the pass

## Operation

- States:
  - IDLE
  - FILL: 9 reads, in column order j=0..2, and top to bottom within each column
  - SHIFT: 3 reads of the new right column; taps j=1,2 move to j=0,1
  - HOLD: win_valid=1
  - DONE: done pulse, then back to IDLE
- IDLE -> FILL on start.
- FILL/SHIFT -> HOLD once the last tap is captured.
- HOLD on handshake:
  - more columns in the current row -> SHIFT
  - else more rows -> FILL at column 0 of the next row
  - else -> DONE
- No padding (default):
  - win_row/win_col give the top-left corner, 0..61.
  - Rows are scanned top to bottom, columns left to right.
  - 3844 windows per pass.
- start while busy is ignored.
- win_ready may be high before win_valid.
- In HOLD, win_data, win_row, win_col, win_last and rd_addr are all frozen, and no reads are issued.
- Address arithmetic is ADDR_W-bit unsigned; out-of-image addresses are never driven.

## Timing

- Reset (asynchronous):
  - all outputs are 0 and the state is IDLE immediately
  - any pass in progress is discarded
  - on deassertion the block waits for a new start
- Read pipeline: rd_addr is registered at edge E. BRAM samples it at E+1. The block captures rd_data at E+2. Exactly one read is issued per cycle, back to back.
- Start accepted at edge E0: tap addresses appear after E0..E8. The last capture is at E10. win_valid is high in the cycle after E10 and first samples high at E11.
- Handshake at edge H:
  - SHIFT: win_valid samples high again at H+5.
  - FILL: win_valid samples high again at H+11.
- win_valid deasserts the cycle after the handshake.
- done is high for exactly the cycle after the final handshake. busy falls in that same cycle.

## Configuration

- ZERO_PAD_EN defined:
  - "same" padding: 4096 windows.
  - win_row/win_col give the window centre, 0..63; tap (i,j) is the pixel at (row-1+i, col-1+j).
  - Out-of-image taps still occupy their read slot, so latency is unchanged.
  - For those taps rd_addr = 0 and the captured value is forced to 0.
  - win_last is high on (63,63).
- ZERO_PAD_EN undefined:
  - valid convolution as described above.
  - No padding logic is compiled in.

## Test plan

- Preload mem[a] = a[7:0] and pulse start with win_ready=1 -> first window (0,0) has taps 0,1,2,64,65,66,128,129,130 (low bytes), and win_valid first samples high 11 cycles after start.
- Full pass with win_ready=1 -> exactly 3844 handshakes in raster order, then:
  - win_last only on (61,61), with taps = low bytes of addresses 3965,3966,3967,4029,4030,4031,4093,4094,4095
  - done pulses once, and busy falls in the same cycle
- Hold win_ready=0 for 20 cycles on window (0,5) -> win_data and rd_addr stay constant, and the next window is (0,6), arriving 5 cycles after the handshake.
- Row change at (0,61) -> (1,0): 11 cycles from handshake to the next valid, with 9 distinct addresses 64,128,192,65,...,194.
- Assert rst during window (10,20) -> all outputs are 0 immediately; a new start produces window (0,0) with correct taps.
- With ZERO_PAD_EN: window (0,0) taps = 0,0,0,0,mem[0],mem[1],0,mem[64],mem[65]; 4096 windows in total; win_last on (63,63).
